// File: rtl/pcn_predict_if.sv
// Fetch-lookup and execute-resolve signal bundle for the next-PC predictor.
// The pipeline holds the master modport and the predictor holds the slave modport.
interface pcn_predict_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] fetch_pc_i;
  logic                  pred_taken_o;
  logic [DATA_WIDTH-1:0] pred_target_o;
  logic                  resolve_valid_i;
  logic [DATA_WIDTH-1:0] resolve_pc_i;
  logic [2:0]            specinst_i;
  logic [2:0]            detail_i;
  logic                  cmp_i;
  logic [DATA_WIDTH-1:0] take_target;
  logic [DATA_WIDTH-1:0] nonetake_target;
  logic                  pred_taken_i;
  logic [DATA_WIDTH-1:0] pred_target_i;
  logic                  redirect_valid_o;
  logic [DATA_WIDTH-1:0] redirect_pc_o;

  modport master (
    output fetch_pc_i, resolve_valid_i, resolve_pc_i, specinst_i, detail_i, cmp_i,
           take_target, nonetake_target, pred_taken_i, pred_target_i,
    input  pred_taken_o, pred_target_o, redirect_valid_o, redirect_pc_o
  );

  modport slave (
    input  fetch_pc_i, resolve_valid_i, resolve_pc_i, specinst_i, detail_i, cmp_i,
           take_target, nonetake_target, pred_taken_i, pred_target_i,
    output pred_taken_o, pred_target_o, redirect_valid_o, redirect_pc_o
  );
endinterface

// File: rtl/pcn_predict.sv
// Next-PC predictor: 2-bit counter BHT + tagged BTB looked up at fetch, resolved and trained at execute.
// Optional macro PCN_PERF_CNT_EN adds branch / mispredict performance counters.
module pcn_predict #(
  parameter int         DATA_WIDTH = 64,
  parameter int         BHT_DEPTH  = 64,
  parameter logic [1:0] INIT_CNT   = 2'b01
) (
  input  logic          clk,
  input  logic          rst_n,
  pcn_predict_if.slave  bus
`ifdef PCN_PERF_CNT_EN
  ,
  output logic [31:0]   perf_branches_o,
  output logic [31:0]   perf_mispred_o
`endif
);
  localparam int IW = $clog2(BHT_DEPTH);
  localparam int TW = DATA_WIDTH - IW - 2;

  localparam logic [2:0] SPEC_BR   = 3'd0;
  localparam logic [2:0] SPEC_JAL  = 3'd1;
  localparam logic [2:0] SPEC_JALR = 3'd2;

  logic [1:0]            cnt        [BHT_DEPTH];
  logic                  btb_valid  [BHT_DEPTH];
  logic [TW-1:0]         btb_tag    [BHT_DEPTH];
  logic [DATA_WIDTH-1:0] btb_target [BHT_DEPTH];

  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;

  logic [IW-1:0]         f_idx;
  logic [TW-1:0]         f_tag;
  logic                  f_hit;
  logic                  f_taken;

  logic [IW-1:0]         r_idx;
  logic [TW-1:0]         r_tag;
  logic                  is_ctrl;
  logic                  qualified;
  logic                  actual_taken;
  logic [DATA_WIDTH-1:0] actual_pc;
  logic                  mispredict;

  logic                  unused_pc_bits;
  assign unused_pc_bits = ^{bus.fetch_pc_i[1:0], bus.resolve_pc_i[1:0]};

  // Lookup reads the registered tables only, so a same-cycle write is not visible yet.
  assign f_idx   = bus.fetch_pc_i[IW+1:2];
  assign f_tag   = bus.fetch_pc_i[DATA_WIDTH-1:IW+2];
  assign f_hit   = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
  assign f_taken = f_hit && cnt[f_idx][1];

  assign bus.pred_taken_o  = f_taken;
  assign bus.pred_target_o = f_taken ? btb_target[f_idx] : bus.fetch_pc_i + DATA_WIDTH'(4);

  assign r_idx = bus.resolve_pc_i[IW+1:2];
  assign r_tag = bus.resolve_pc_i[DATA_WIDTH-1:IW+2];

  always_comb begin
    actual_taken = 1'b0;
    case (bus.specinst_i)
      SPEC_BR: begin
        case (bus.detail_i)
          3'b000, 3'b100, 3'b110: actual_taken = bus.cmp_i;
          3'b001, 3'b101, 3'b111: actual_taken = ~bus.cmp_i;
          default:                actual_taken = 1'b0;
        endcase
      end
      SPEC_JAL, SPEC_JALR: actual_taken = 1'b1;
      default:             actual_taken = 1'b0;
    endcase
  end

  assign is_ctrl    = (bus.specinst_i == SPEC_BR) || (bus.specinst_i == SPEC_JAL) ||
                      (bus.specinst_i == SPEC_JALR);
  // The instruction resolving while a redirect is out is on the wrong path.
  assign qualified  = bus.resolve_valid_i && !redirect_valid && is_ctrl;
  assign actual_pc  = actual_taken ? bus.take_target : bus.nonetake_target;
  assign mispredict = (actual_taken != bus.pred_taken_i) ||
                      (actual_taken && (bus.take_target != bus.pred_target_i));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        cnt[i]        <= INIT_CNT;
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
      end
    end else if (qualified) begin
      if (bus.specinst_i == SPEC_BR) begin
        if (actual_taken && cnt[r_idx] != 2'b11)
          cnt[r_idx] <= cnt[r_idx] + 2'b01;
        else if (!actual_taken && cnt[r_idx] != 2'b00)
          cnt[r_idx] <= cnt[r_idx] - 2'b01;
      end else begin
        cnt[r_idx] <= 2'b11;
      end
      if (actual_taken) begin
        btb_valid[r_idx]  <= 1'b1;
        btb_tag[r_idx]    <= r_tag;
        btb_target[r_idx] <= bus.take_target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= qualified && mispredict;
      if (qualified && mispredict)
        redirect_pc <= actual_pc;
    end
  end

  assign bus.redirect_valid_o = redirect_valid;
  assign bus.redirect_pc_o    = redirect_pc;

`ifdef PCN_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches_o <= '0;
      perf_mispred_o  <= '0;
    end else if (qualified) begin
      perf_branches_o <= perf_branches_o + 32'd1;
      if (mispredict)
        perf_mispred_o <= perf_mispred_o + 32'd1;
    end
  end
`endif

endmodule
